countdown_timer: RTL
====================

COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 Parameter CLK_FREQ, default 50_000_000, input clock frequency in Hz.
REQ-002 Parameter TICK_DIV, default CLK_FREQ, clock cycles per countdown second; overridable (e.g. 4) for simulation.
REQ-003 Parameter MIN_SEC, default 5, lower clamp bound for the loaded value.
REQ-004 Parameter MAX_SEC, default 15, upper clamp bound for the loaded value.
REQ-005 One clock; reset is asynchronous and active-low.
REQ-006 clk  input  1  system clock, all state on rising edge.
REQ-007 rst_n  input  1  asynchronous active-low reset.
REQ-008 start  input  1  single-cycle pulse; loads and starts the countdown.
REQ-009 load_val  input  8  requested duration in seconds, sampled only when start=1.
REQ-010 pause  input  1  level; holds prescaler and count while high.
REQ-011 cancel  input  1  single-cycle pulse; aborts the countdown.
REQ-012 countdown_val  output  8  remaining seconds, drives the display countdown field; 0 when idle.
REQ-013 active  output  1  high while a countdown is running or paused.
REQ-014 done  output  1  one-cycle pulse on natural expiry only.

Function
REQ-015 FSM states: IDLE, RUN, EXPIRE; EXPIRE lasts exactly one cycle, then IDLE.
REQ-016 Clamp rule: load_val<MIN_SEC loads MIN_SEC; load_val>MAX_SEC loads MAX_SEC; otherwise loads load_val unchanged.
REQ-017 start in any state with cancel=0 -> next cycle: state RUN, countdown_val=clamped value, active=1, prescaler=0 (restart from any state, including RUN).
REQ-018 Prescaler counts 0..TICK_DIV-1 in RUN while pause=0; wraps to 0 on reaching TICK_DIV-1 and generates one internal tick.
REQ-019 Each tick decrements countdown_val by 1; no other event alters it in RUN.
REQ-020 Tick while countdown_val=1 -> next cycle: countdown_val=0, state EXPIRE, done=1, active=0.
REQ-021 Unpaused run duration: first visible value to done assertion = clamped_value*TICK_DIV cycles.
REQ-022 pause=1 freezes prescaler and countdown_val; active stays 1; resume continues from the frozen prescaler value.
REQ-023 pause has no effect in IDLE/EXPIRE.
REQ-024 cancel in RUN -> next cycle: IDLE, countdown_val=0, active=0, done stays 0.
REQ-025 cancel and start in the same cycle: cancel wins, start ignored.
REQ-026 start and an expiring tick in the same cycle: start wins, done not asserted.
REQ-027 countdown_val never wraps below 0 and never exceeds MAX_SEC.
REQ-028 Prescaler width: ceil(log2(TICK_DIV)) bits minimum; 26 bits suffices at default.

Reset
REQ-029 rst_n=0 at any time, including mid-countdown, -> immediately: state IDLE, countdown_val=0, active=0, done=0, prescaler=0.
REQ-030 After reset release the block stays IDLE until a start pulse.

Verification (TICK_DIV=4)
REQ-031 start, load_val=10 -> countdown_val=10 next cycle, decrements every 4 cycles, done one cycle at cycle 40, countdown_val=0, active=0.
REQ-032 load_val=2 -> loads 5; load_val=200 -> loads 15; load_val=0 -> loads 5.
REQ-033 start(7), pause high 9 cycles after 2 ticks -> countdown_val holds 5 for the 9 cycles; done 37 cycles after load (28+9).
REQ-034 cancel while countdown_val=3 -> countdown_val=0, active=0, no done pulse; cancel+start same cycle -> stays IDLE.
REQ-035 Restart: start(6) then start(12) while countdown_val=4 -> countdown_val=12, prescaler restarted, done 48 cycles after second start.
REQ-036 rst_n low while countdown_val=8 -> outputs 0 asynchronously, no done; block stays IDLE after release.

Source files
------------

// File: rtl/countdown_timer.sv
// -----------------------------------------------------------------------------
// countdown_timer
//
// Loadable seconds countdown for a display field. A start pulse samples
// load_val, clamps it into [MIN_SEC, MAX_SEC] and begins counting down one
// second every TICK_DIV clock cycles. A level pause freezes the count and the
// sub-second prescaler. A cancel pulse aborts back to idle without signalling
// completion. Natural expiry produces a one-cycle done pulse.
//
// Parameters
//   CLK_FREQ  input clock frequency in Hz
//   TICK_DIV  clock cycles per countdown second (small values for simulation)
//   MIN_SEC   lowest value a start may load
//   MAX_SEC   highest value a start may load
//
// Ports
//   clk            system clock, all state on rising edge
//   rst_n          asynchronous active-low reset
//   start          single-cycle pulse, loads and (re)starts the countdown
//   load_val       requested duration in seconds, sampled only with start
//   pause          level, holds prescaler and count while high
//   cancel         single-cycle pulse, aborts the countdown (beats start)
//   countdown_val  remaining seconds, 0 when idle
//   active         high while a countdown is running or paused
//   done           one-cycle pulse on natural expiry only
// -----------------------------------------------------------------------------
module countdown_timer #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int TICK_DIV = CLK_FREQ,
    parameter int MIN_SEC  = 5,
    parameter int MAX_SEC  = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] load_val,
    input  logic       pause,
    input  logic       cancel,
    output logic [7:0] countdown_val,
    output logic       active,
    output logic       done
);

    // A divide-by-one prescaler still needs one bit to exist.
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0] PRESC_ZERO = '0;
    localparam logic [PW-1:0] PRESC_ONE  = PW'(1);
    localparam logic [7:0]    MIN_V      = 8'(MIN_SEC);
    localparam logic [7:0]    MAX_V      = 8'(MAX_SEC);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        EXPIRE = 2'd2
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [7:0]      count_q;
    logic [7:0]      count_d;
    logic [PW-1:0]   presc_q;
    logic [PW-1:0]   presc_d;
    logic [7:0]      clamped;
    logic            tick;

    // Clamp the requested duration into the legal window before it is loaded,
    // so the count can never start above MAX_SEC.
    always_comb begin
        clamped = load_val;
        if (load_val < MIN_V) begin
            clamped = MIN_V;
        end else if (load_val > MAX_V) begin
            clamped = MAX_V;
        end
    end

    // One-second tick: the prescaler is on its last step of a running,
    // unpaused second.
    always_comb begin
        tick = (state_q == RUN) && !pause && (presc_q == PRESC_LAST);
    end

    // State register together with the count and prescaler it qualifies.
    // Reset clears everything immediately, including mid-countdown.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            count_q <= 8'd0;
            presc_q <= PRESC_ZERO;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            presc_q <= presc_d;
        end
    end

    // Next-state logic. Priority is cancel, then start, then the normal state
    // behaviour, so cancel overrides a simultaneous start and start overrides
    // an expiring tick (which therefore never produces done).
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        presc_d = presc_q;

        if (cancel) begin
            state_d = IDLE;
            count_d = 8'd0;
            presc_d = PRESC_ZERO;
        end else if (start) begin
            state_d = RUN;
            count_d = clamped;
            presc_d = PRESC_ZERO;
        end else begin
            case (state_q)
                RUN: begin
                    if (tick) begin
                        presc_d = PRESC_ZERO;
                        // Last second gone: stop at zero rather than wrap.
                        if (count_q <= 8'd1) begin
                            state_d = EXPIRE;
                            count_d = 8'd0;
                        end else begin
                            count_d = count_q - 8'd1;
                        end
                    end else if (!pause) begin
                        presc_d = presc_q + PRESC_ONE;
                    end
                end
                EXPIRE: begin
                    state_d = IDLE;
                    count_d = 8'd0;
                    presc_d = PRESC_ZERO;
                end
                default: begin
                    state_d = IDLE;
                    count_d = 8'd0;
                    presc_d = PRESC_ZERO;
                end
            endcase
        end
    end

    // Outputs decode directly from the registered state, so done is exactly
    // the single EXPIRE cycle and active covers running and paused alike.
    always_comb begin
        active        = 1'b0;
        done          = 1'b0;
        countdown_val = 8'd0;
        case (state_q)
            RUN: begin
                active        = 1'b1;
                countdown_val = count_q;
            end
            EXPIRE: begin
                done = 1'b1;
            end
            default: begin
                active        = 1'b0;
            end
        endcase
    end

    // Structural invariants of the counter.
    a_never_above_max: assert property (
        @(posedge clk) disable iff (!rst_n) count_q <= MAX_V
    );

    a_done_means_zero: assert property (
        @(posedge clk) disable iff (!rst_n) done |-> (countdown_val == 8'd0)
    );

    a_done_not_active: assert property (
        @(posedge clk) disable iff (!rst_n) !(done && active)
    );

    a_expire_one_cycle: assert property (
        @(posedge clk) disable iff (!rst_n) (state_q == EXPIRE) |=> (state_q != EXPIRE)
    );

endmodule
